mux16_rr_sched: RTL
===================

Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares the 16-input, 4-bit select datapath among 16 requesters.
- Each cycle it picks one requesting source and drives the select as {s0, s1[2:0]}.
- It registers the selected word into a one-entry output buffer and presents it downstream with a valid/ready handshake.
- It sits between the 16 producer ports and a single consumer, and owns the mux select.

Parameters:
- W, 4, data width per source. Default matches the existing 4-bit mux lanes.
- N, 16, number of sources. Fixed at 16. Select is 4 bits.

Ports:
- clk  in  1  rising-edge clock. This is the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  16  req[k]=1: source k has a valid word on din[k*W +: W].
- din  in  16*W  flattened source data. Source k occupies bits [k*W+W-1 : k*W].
- ack  out  16  one-hot, single-cycle pulse. Source k's word was captured this cycle.
- s1  out  3  mux select low bits, equal to sel[2:0].
- s0  out  1  mux select high bit, equal to sel[3]. s0=1 selects sources 8..15.
- out_valid  out  1  the output buffer holds a word.
- out_data  out  W  buffered word.
- out_src  out  4  index of the source that produced out_data.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both 1.

Behaviour:
- Reset (rst=1 at a clk edge) applies regardless of state. It overrides any pending handshake, and the in-flight word is discarded. After reset:
  - out_valid=0, out_data=0, out_src=0, ack=0.
  - ptr=15, so source 0 has top priority on the first arbitration.
  - sel=0, so s1=0 and s0=0.
  - state=IDLE.
- States: IDLE (buffer empty) and FULL (buffer holds a word).
- can_load = (state==IDLE) or (out_valid and out_ready).
- Arbitration is combinational every cycle:
  - Winner w = first k with req[k]=1, scanning ptr+1, ptr+2, ..., ptr+16, all mod 16.
  - If req=0, there is no winner.
- Select outputs:
  - sel is registered and updated only on a capture.
  - sel={s0,s1} equals out_src while FULL and holds its last value while IDLE.
  - The datapath word is sampled combinationally from din[w] in the capture cycle, so capture has no mux-pipeline dependency.
- Capture happens when can_load=1 and a winner exists. At the next edge:
  - out_data <= din[w], out_src <= w, sel <= w, ptr <= w.
  - out_valid <= 1, state <= FULL.
  - ack[w]=1 during the capture cycle. This is combinational, same cycle as the edge that captures.
- The source must drop req, or present its next word, on the cycle after ack. A held req is treated as a new word.
- FULL with out_ready=0: hold every registered output. ack=0. req is ignored.
- FULL with out_ready=1 and a winner: back-to-back. The next word is captured at the same edge the current one is consumed, so out_valid stays 1. Throughput is 1 word/cycle.
- FULL with out_ready=1 and no winner: out_valid <= 0, state <= IDLE. out_data and out_src hold their stale values.
- Latency: req to out_valid is 1 cycle from IDLE.
- Fairness: the last grantee gets the lowest priority. With all 16 requesting continuously and out_ready=1, grants cycle 0,1,...,15,0. No source waits more than 15 grants.
- Wrap-around: ptr=15 means the scan starts at 0. ptr=w with only req[w] set means w wins again after scanning 15 empty positions.
- out_ready while IDLE is ignored.
- At most one ack bit is set in any cycle.
- Assertions:
  - ack is one-hot or zero.
  - ack is nonzero only when can_load=1.
  - out_data and out_src are stable while out_valid and !out_ready.

Test Plan:
- Reset, then single request: rst for 2 cycles, then req=16'h0001, din[0]=4'hA, out_ready=1.
  - Expect ack[0] in that cycle.
  - Next cycle: out_valid=1, out_data=A, out_src=0, s0=0, s1=0.
- Round-robin full load: req=16'hFFFF held, din[k]=k, out_ready=1 for 20 cycles.
  - Expect out_src sequence 0,1,...,15,0,1,2,3 with out_valid continuously 1.
  - Expect s0=1 exactly while out_src is in 8..15.
- Backpressure: capture source 5 (din=4'h7), then out_ready=0 for 4 cycles while req=16'h0300.
  - Expect out_data=7 and out_src=5 held, with ack=0 throughout.
  - On out_ready=1, expect 8 captured at that edge, then 9 next.
- Wrap priority: after a grant to 14, req=16'h8001.
  - Expect 15 granted before 0. Next grant 0.
- Drain to IDLE: capture source 3, then req=0, out_ready=1.
  - Expect out_valid to fall after 1 cycle, and s1=3, s0=0 retained.
- Reset mid-transfer: buffer FULL with out_ready=0, then rst=1 for 1 cycle.
  - Expect out_valid=0 and ack=0.
  - Then req=16'h0006 yields grant to 1 (ptr reset to 15).

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a 16-source, 4-bit-select mux datapath.
// One source is picked per cycle, and its word is captured into a one-entry
// output buffer. The buffer is drained downstream with a valid/ready handshake.
module mux16_rr_sched #(
  parameter int unsigned W = 4,   // data width per source
  parameter int unsigned N = 16   // number of sources; select logic assumes 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   din,
  output logic [N-1:0]     ack,
  output logic [2:0]       s1,
  output logic             s0,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [3:0]       out_src,
  input  logic             out_ready
);

  localparam int unsigned SEL_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  // Registered state
  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  // Combinational arbitration and control
  logic             found_c;
  logic [SEL_W-1:0] win_c;
  logic [SEL_W-1:0] idx_c;
  logic [W-1:0]     din_word_c;
  logic             can_load_c;
  logic             capture_c;
  logic [N-1:0]     ack_c;

  // Rotating priority scan: start just after the last grantee, wrap at 16.
  always_comb begin
    found_c = 1'b0;
    win_c   = ptr_q;
    idx_c   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx_c = ptr_q + SEL_W'(i);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Word presented by the current winner, taken straight from the source lanes.
  always_comb begin
    din_word_c = din[32'(win_c)*W +: W];
  end

  // Buffer can accept when empty or when its word leaves at this edge.
  always_comb begin
    can_load_c = (state_q == IDLE) || (out_valid_q && out_ready);
    capture_c  = can_load_c && found_c;
  end

  // Next-state and next-register logic; defaults hold everything.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ack_c       = '0;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready && !found_c) begin
          // Consumed with nothing to refill: data/src keep their stale values.
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture_c) begin
      out_data_d   = din_word_c;
      out_src_d    = win_c;
      sel_d        = win_c;
      ptr_d        = win_c;
      out_valid_d  = 1'b1;
      state_d      = FULL;
      ack_c[win_c] = 1'b1;
    end
  end

  // State registers with synchronous reset; ptr=15 gives source 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= SEL_W'(N - 1);
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  // Output mapping; ack is the capture strobe and is combinational by design.
  assign ack       = ack_c;
  assign s1        = sel_q[2:0];
  assign s0        = sel_q[3];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // At most one source acknowledged per cycle.
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack_c));

  // Acks only occur when the buffer can take a word.
  a_ack_load: assert property (@(posedge clk) disable iff (rst) (ack_c != '0) |-> can_load_c);

  // A stalled word must not change.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !out_ready) |=> ($stable(out_data_q) && $stable(out_src_q)));

endmodule
